// File: rtl/hsi_m_cmd_tx.sv
// HSI master command transmitter: one-deep holding register feeding a
// slot-paced serialiser that drives the com1/com2 line pair.
module hsi_m_cmd_tx #(
    parameter int GAP_TICKS = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clk_en,
    input  logic [7:0] d,
    input  logic       d_wr,
    input  logic       d_last,
    output logic       d_rdy,
    output logic       com1,
    output logic       com2,
    output logic       busy,
    output logic       frame_done,
    output logic       tx_underrun,
    output logic       wr_ovf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_H,
        S_START_L,
        S_BIT_H,
        S_BIT_L,
        S_STOP1,
        S_STOP2,
        S_GAP
    } state_t;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] sh, sh_n;
    logic       sh_last, sh_last_n;
    logic       hold_valid;
    logic [7:0] hold_data;
    logic       hold_last;
    logic       take, accept;
    logic       done_n, unr_n;
    logic       bit_n, com1_n, com2_n;

    assign d_rdy  = ~hold_valid;
    assign busy   = (state != S_IDLE);
    // A write coinciding with a take refills the register in the same cycle
    assign accept = d_wr & (~hold_valid | take);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sh_n      = sh;
        sh_last_n = sh_last;
        take      = 1'b0;
        done_n    = 1'b0;
        unr_n     = 1'b0;
        if (clk_en) begin
            unique case (state)
                S_IDLE: begin
                    if (hold_valid) state_n = S_START_H;
                end
                S_START_H: state_n = S_START_L;
                S_START_L: begin
                    take      = 1'b1;
                    sh_n      = hold_data;
                    sh_last_n = hold_last;
                    cnt_n     = 4'd0;
                    state_n   = S_BIT_H;
                end
                S_BIT_H: state_n = S_BIT_L;
                S_BIT_L: begin
                    if (cnt < 4'd8) begin
                        cnt_n   = cnt + 4'd1;
                        state_n = S_BIT_H;
                    end else if (sh_last) begin
                        state_n = S_STOP1;
                    end else if (hold_valid) begin
                        take      = 1'b1;
                        sh_n      = hold_data;
                        sh_last_n = hold_last;
                        cnt_n     = 4'd0;
                        state_n   = S_BIT_H;
                    end else begin
                        unr_n   = 1'b1;
                        state_n = S_STOP1;
                    end
                end
                S_STOP1: begin
                    done_n  = 1'b1;
                    state_n = S_STOP2;
                end
                S_STOP2: begin
                    cnt_n   = 4'd1;
                    state_n = (GAP_TICKS == 1) ? S_IDLE : S_GAP;
                end
                S_GAP: begin
                    if (cnt == 4'(GAP_TICKS - 1)) begin
                        cnt_n   = 4'd0;
                        state_n = S_IDLE;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    // Line levels follow the slot being entered; slot 8 carries odd parity
    always_comb begin
        com1_n = 1'b0;
        com2_n = 1'b0;
        bit_n  = (cnt_n == 4'd8) ? ~^sh_n : sh_n[~cnt_n[2:0]];
        unique case (state_n)
            S_START_H, S_STOP1, S_STOP2: begin
                com1_n = 1'b1;
                com2_n = 1'b1;
            end
            S_BIT_H: begin
                com1_n = bit_n;
                com2_n = ~bit_n;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            sh      <= 8'd0;
            sh_last <= 1'b0;
            com1    <= 1'b0;
            com2    <= 1'b0;
        end else if (clk_en) begin
            state   <= state_n;
            cnt     <= cnt_n;
            sh      <= sh_n;
            sh_last <= sh_last_n;
            com1    <= com1_n;
            com2    <= com2_n;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hold_valid  <= 1'b0;
            hold_data   <= 8'd0;
            hold_last   <= 1'b0;
            frame_done  <= 1'b0;
            tx_underrun <= 1'b0;
            wr_ovf      <= 1'b0;
        end else begin
            if (accept) begin
                hold_valid <= 1'b1;
                hold_data  <= d;
                hold_last  <= d_last;
            end else if (take) begin
                hold_valid <= 1'b0;
            end
            frame_done  <= done_n;
            tx_underrun <= unr_n;
            wr_ovf      <= d_wr & hold_valid & ~take;
        end
    end

endmodule

// File: tb/tb_hsi_m_cmd_tx.sv
// Self-checking bench for hsi_m_cmd_tx: per-tick line trace compared
// against a frame-level model built from byte lists.
module tb_hsi_m_cmd_tx;

    localparam int GAP = 4;

    logic       clk = 0;
    logic       n_rst = 0;
    logic       clk_en = 0;
    logic [7:0] d = 0;
    logic       d_wr = 0;
    logic       d_last = 0;
    logic       d_rdy, com1, com2, busy;
    logic       frame_done, tx_underrun, wr_ovf;

    int n_pass = 0;
    int n_chk  = 0;
    int en_mode = 0;

    logic [1:0] trace[$];
    logic       busy_tr[$];
    int         fd_q[$];
    int         ur_q[$];
    int         rdy_rise[$];
    int         ovf_n = 0;
    logic [1:0] exp_q[$];
    int         exp_fd[$];
    logic       rdy_prev = 1'b1;
    logic       en_s;

    typedef struct {
        logic [7:0] d;
        logic       last;
        logic       par;
        int         ur;
    } vec_t;
    vec_t tbl[6];

    hsi_m_cmd_tx #(.GAP_TICKS(GAP)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .clk_en(clk_en),
        .d(d),
        .d_wr(d_wr),
        .d_last(d_last),
        .d_rdy(d_rdy),
        .com1(com1),
        .com2(com2),
        .busy(busy),
        .frame_done(frame_done),
        .tx_underrun(tx_underrun),
        .wr_ovf(wr_ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        case (en_mode)
            0: clk_en = ~clk_en;
            1: clk_en = 1'b1;
            2: clk_en = ($urandom_range(0, 2) == 0);
            default: clk_en = 1'b0;
        endcase
    end

    always @(posedge clk) begin
        en_s = clk_en;
        #1;
        if (n_rst) begin
            if (en_s) begin
                trace.push_back({com1, com2});
                busy_tr.push_back(busy);
            end
            if (frame_done) fd_q.push_back(trace.size() - 1);
            if (tx_underrun) ur_q.push_back(trace.size() - 1);
            if (wr_ovf) ovf_n++;
            if (d_rdy && !rdy_prev) rdy_rise.push_back(trace.size() - 1);
        end
        rdy_prev = d_rdy;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic clear_mon();
        trace.delete();
        busy_tr.delete();
        fd_q.delete();
        ur_q.delete();
        rdy_rise.delete();
        ovf_n = 0;
    endtask

    task automatic wr(input logic [7:0] b, input logic l);
        @(negedge clk);
        d = b;
        d_last = l;
        d_wr = 1'b1;
        @(negedge clk);
        d_wr = 1'b0;
    endtask

    task automatic wait_rdy();
        int k = 0;
        while (!d_rdy && k < 4000) begin
            @(negedge clk);
            k++;
        end
        if (!d_rdy) chk("rdy_timeout", 0, 1);
    endtask

    task automatic wait_size(input int target);
        int k = 0;
        while (trace.size() < target && k < 8 * target + 200) begin
            @(negedge clk);
            k++;
        end
        if (trace.size() < target) chk("tick_timeout", trace.size(), target);
    endtask

    task automatic wait_ticks(input int n);
        wait_size(trace.size() + n);
    endtask

    function automatic int find_start(input int from);
        for (int i = from; i < trace.size(); i++)
            if (trace[i] == 2'b11) return i;
        return -1;
    endfunction

    function automatic void add_bit(input logic b);
        exp_q.push_back(b ? 2'b10 : 2'b01);
        exp_q.push_back(2'b00);
    endfunction

    function automatic void add_start();
        exp_q.push_back(2'b11);
        exp_q.push_back(2'b00);
    endfunction

    function automatic void add_byte(input logic [7:0] b, input logic p);
        for (int i = 7; i >= 0; i--) add_bit(b[i]);
        add_bit(p);
    endfunction

    function automatic void add_stop_gap();
        exp_q.push_back(2'b11);
        exp_q.push_back(2'b11);
        for (int i = 0; i < GAP; i++) exp_q.push_back(2'b00);
    endfunction

    function automatic logic odd_par(input logic [7:0] b);
        return ($countones(b) % 2) == 0;
    endfunction

    task automatic cmp_trace(input string nm, input int s);
        int bad = -1;
        logic [1:0] act = 2'bxx;
        if (s < 0) bad = 0;
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (s + i >= trace.size()) begin
                    bad = i;
                    break;
                end
                if (trace[s + i] !== exp_q[i]) begin
                    bad = i;
                    act = trace[s + i];
                    break;
                end
            end
        end
        n_chk++;
        if (bad < 0) n_pass++;
        else $display("FAIL %s: tick %0d lines %b, expected %b",
                      nm, bad, act, exp_q[bad]);
    endtask

    initial begin
        int s, s2, n, off;
        logic [7:0] b;

        tbl[0] = '{8'hA5, 1'b1, 1'b1, 0};
        tbl[1] = '{8'h00, 1'b1, 1'b1, 0};
        tbl[2] = '{8'hFF, 1'b1, 1'b1, 0};
        tbl[3] = '{8'h01, 1'b1, 1'b0, 0};
        tbl[4] = '{8'h3C, 1'b0, 1'b1, 1};
        tbl[5] = '{8'h80, 1'b0, 1'b0, 1};

        en_mode = 0;
        repeat (3) @(negedge clk);
        chk("reset_state",
            int'({com1, com2, busy, d_rdy, frame_done, tx_underrun, wr_ovf}),
            int'(7'b0001000));
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // single-byte frames, clk_en every second clk
        for (int t = 0; t < 6; t++) begin
            clear_mon();
            wr(tbl[t].d, tbl[t].last);
            wait_ticks(32);
            s = find_start(0);
            chk($sformatf("start_lat_%0d", t), int'(s >= 0 && s <= 2), 1);
            exp_q.delete();
            add_start();
            add_byte(tbl[t].d, tbl[t].par);
            add_stop_gap();
            cmp_trace($sformatf("frame_%0d", t), s);
            chk($sformatf("fd_tick_%0d", t),
                fd_q.size() == 1 ? fd_q[0] : -1, s + 21);
            chk($sformatf("ur_cnt_%0d", t), ur_q.size(), tbl[t].ur);
            if (tbl[t].ur != 0)
                chk($sformatf("ur_tick_%0d", t), ur_q[0], s + 20);
            chk($sformatf("busy_end_%0d", t),
                int'({busy_tr[s + 20 + GAP], busy_tr[s + 21 + GAP]}), 2);
            chk($sformatf("idle_%0d", t), int'({busy, d_rdy}), 1);
        end

        // two-byte frame, second byte written while first shifts
        clear_mon();
        wr(8'h00, 1'b0);
        chk("rdy_fall_1", int'(d_rdy), 0);
        wait_rdy();
        wr(8'hFF, 1'b1);
        chk("rdy_fall_2", int'(d_rdy), 0);
        wait_ticks(46);
        s = find_start(0);
        exp_q.delete();
        add_start();
        add_byte(8'h00, 1'b1);
        add_byte(8'hFF, 1'b1);
        add_stop_gap();
        cmp_trace("two_byte", s);
        chk("two_byte_fd", fd_q.size() == 1 ? fd_q[0] : -1, s + 39);
        chk("rdy_rise_n", rdy_rise.size(), 2);
        if (rdy_rise.size() == 2) begin
            chk("rdy_rise_0", rdy_rise[0], s + 2);
            chk("rdy_rise_1", rdy_rise[1], s + 20);
        end

        // overflow: two writes with no slot tick between
        clear_mon();
        en_mode = 3;
        repeat (2) @(negedge clk);
        d = 8'hA1;
        d_last = 1'b1;
        d_wr = 1'b1;
        @(negedge clk);
        d = 8'h5E;
        @(negedge clk);
        d_wr = 1'b0;
        chk("ovf_rdy", int'(d_rdy), 0);
        repeat (2) @(negedge clk);
        en_mode = 0;
        wait_ticks(32);
        s = find_start(0);
        exp_q.delete();
        add_start();
        add_byte(8'hA1, 1'b0);
        add_stop_gap();
        cmp_trace("ovf_frame", s);
        chk("ovf_pulses", ovf_n, 1);
        chk("ovf_fd", fd_q.size(), 1);

        // freeze then reset at tick 7
        clear_mon();
        wr(8'hC3, 1'b1);
        wait_ticks(3);
        s = find_start(0);
        wait_size(s + 7);
        en_mode = 3;
        repeat (10) @(negedge clk);
        chk("freeze_lines", int'({com1, com2}), int'(2'b01));
        chk("freeze_ticks", trace.size(), s + 7);
        #2;
        n_rst = 1'b0;
        #1;
        chk("rst_mid", int'({com1, com2, busy, d_rdy}), int'(4'b0001));
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_no_done", fd_q.size() + ur_q.size(), 0);
        clear_mon();
        en_mode = 0;
        wr(8'h5A, 1'b1);
        wait_ticks(32);
        s = find_start(0);
        exp_q.delete();
        add_start();
        add_byte(8'h5A, 1'b1);
        add_stop_gap();
        cmp_trace("post_rst", s);
        chk("post_rst_fd", fd_q.size(), 1);

        // next byte written during stop starts after exactly GAP idle ticks
        clear_mon();
        wr(8'h96, 1'b1);
        wait_ticks(3);
        s = find_start(0);
        wait_size(s + 21);
        wr(8'h69, 1'b1);
        wait_ticks(40);
        s2 = find_start(s + 22);
        chk("gap_start", s2, s + 22 + GAP);
        exp_q.delete();
        add_start();
        add_byte(8'h96, odd_par(8'h96));
        add_stop_gap();
        add_start();
        add_byte(8'h69, odd_par(8'h69));
        add_stop_gap();
        cmp_trace("gap_pair", s);

        // randomised frames with random clk_en density
        clear_mon();
        exp_q.delete();
        exp_fd.delete();
        en_mode = 2;
        off = 0;
        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(1, 4);
            add_start();
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                add_byte(b, odd_par(b));
                wait_rdy();
                wr(b, j == n - 1);
            end
            add_stop_gap();
            exp_fd.push_back(off + 3 + 18 * n);
            off += 4 + 18 * n + GAP;
        end
        wait_size(exp_q.size() + 4);
        s = find_start(0);
        cmp_trace("rand_trace", s);
        chk("rand_fd_n", fd_q.size(), exp_fd.size());
        for (int i = 0; i < exp_fd.size() && i < fd_q.size(); i++)
            chk($sformatf("rand_fd_%0d", i), fd_q[i], s + exp_fd[i]);
        chk("rand_ur", ur_q.size(), 0);
        chk("rand_ovf", ovf_n, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
